// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// FSM encoding, buffer/BCD geometry and small digit helpers.
package seg_pkg;

    localparam int BIN_W = 32;
    localparam int NDIG  = 8;
    localparam int BCD_W = 40;
    localparam int NBCD  = BCD_W / 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    typedef logic [NDIG*4-1:0] disp_t;
    typedef logic [BCD_W-1:0]  bcd_t;

    // Index of the most-significant nonzero digit; 0 when the buffer is all zero.
    function automatic logic [2:0] msd_pos(input disp_t d);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (d[4*i +: 4] != 4'd0) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic bcd_t dabble_adjust(input bcd_t b);
        bcd_t r;
        r = b;
        for (int i = 0; i < NBCD; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Request channel into the scan controller: a value plus hex/decimal select,
// transferred on valid & ready.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [BIN_W-1:0] req_data;
    logic             req_hex;

    modport master (
        output req_valid,
        output req_data,
        output req_hex,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_hex,
        output req_ready
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 32 shift-add-3 steps, one per clock,
// started by a one-cycle start pulse.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output bcd_t             bcd
);

    logic             run_q;
    logic [4:0]       cnt_q;
    logic [BIN_W-1:0] sh_q;
    bcd_t             bcd_q;
    bcd_t             adj;

    assign adj = dabble_adjust(bcd_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= 5'd0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= 5'd0;
        end else if (run_q) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) run_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            sh_q  <= bin;
            bcd_q <= '0;
        end else if (run_q) begin
            bcd_q <= {adj[BCD_W-2:0], sh_q[BIN_W-1]};
            sh_q  <= {sh_q[BIN_W-2:0], 1'b0};
        end
    end

    // done flags the cycle whose closing edge performs the final step,
    // so bcd holds the finished result from the following cycle on.
    assign done = run_q && (cnt_q == 5'd31);
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Display controller: accepts a value, converts it to hex or decimal digits
// into an 8-digit buffer, and time-multiplexes the buffer onto one digit output.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 150000,
    parameter int BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_scan_ctrl_if.slave       req,
    output logic [3:0]           dig,
    output logic [2:0]           pos,
    output logic                 point,
    output logic                 off,
    output logic                 busy,
    output logic                 ovf
);

    localparam int CW = $clog2(SCAN_DIV);

    state_e           state_q, state_d;
    disp_t            disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [BIN_W-1:0] data_q;
    logic             hex_q;
    logic [CW-1:0]    scnt_q;
    logic [2:0]       pos_q;

    logic             ready;
    logic             accept;
    logic             conv_start;
    logic             conv_done;
    bcd_t             conv_bcd;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (req.req_data),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign ready         = (state_q == IDLE);
    assign accept        = req.req_valid && ready;
    assign req.req_ready = ready;
    assign busy          = ~ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= req.req_data;
            hex_q  <= req.req_hex;
        end
    end

    always_comb begin
        state_d    = state_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    conv_start = !req.req_hex;
                    state_d    = req.req_hex ? COMMIT : CONV;
                end
            end
            CONV: begin
                if (conv_done) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (hex_q) begin
                    disp_d = data_q;
                    ovf_d  = 1'b0;
                end else begin
                    // Only eight digits fit; digits 8 and 9 are dropped and flagged.
                    disp_d = conv_bcd[NDIG*4-1:0];
                    ovf_d  = |conv_bcd[BCD_W-1:NDIG*4];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q <= '0;
            pos_q  <= 3'd0;
        end else if (scnt_q == CW'(SCAN_DIV - 1)) begin
            scnt_q <= '0;
            pos_q  <= pos_q + 3'd1;
        end else begin
            scnt_q <= scnt_q + 1'b1;
        end
    end

    assign pos   = pos_q;
    assign dig   = disp_q[{pos_q, 2'b00} +: 4];
    assign off   = (BLANK_LZ != 0) && (pos_q > msd_pos(disp_q));
    assign point = (pos_q == 3'd7) && ovf_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a digit-arithmetic reference model.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dig;
    logic [2:0] pos;
    logic       point, off, busy, ovf;

    always #5 clk = ~clk;

    seg_scan_ctrl_if rq();

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (rq),
        .dig   (dig),
        .pos   (pos),
        .point (point),
        .off   (off),
        .busy  (busy),
        .ovf   (ovf)
    );

    int total = 0;
    int bad   = 0;

    // Clock edges seen since reset release; the scan position follows from it.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int m_dig [8];
    bit m_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_pos();
        return (cyc / SD) % 8;
    endfunction

    function automatic int m_msd();
        int r = 0;
        for (int i = 0; i < 8; i++) if (m_dig[i] != 0) r = i;
        return r;
    endfunction

    task automatic model_set(input logic [31:0] v, input bit hex);
        longint x;
        x = longint'(v);
        if (hex) begin
            for (int i = 0; i < 8; i++) m_dig[i] = int'(v[4*i +: 4]);
            m_ovf = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                m_dig[i] = int'(x % 10);
                x = x / 10;
            end
            m_ovf = (longint'(v) >= 64'd100000000);
        end
    endtask

    task automatic check_scan(input string tag);
        int p;
        p = exp_pos();
        check({tag, "_pos"},   64'(pos),   64'(p));
        check({tag, "_dig"},   64'(dig),   64'(m_dig[p]));
        check({tag, "_off"},   64'(off),   64'(p > m_msd()));
        check({tag, "_point"}, 64'(point), 64'((p == 7) && m_ovf));
        check({tag, "_ovf"},   64'(ovf),   64'(m_ovf));
    endtask

    task automatic txn(input logic [31:0] v, input bit hex, input bit spam, input string tag);
        int old [8];
        int n;
        int p;
        old = m_dig;
        check({tag, "_ready_pre"}, 64'(rq.req_ready), 64'd1);
        rq.req_valid = 1'b1;
        rq.req_data  = v;
        rq.req_hex   = hex;
        tick();
        rq.req_valid = 1'b0;
        rq.req_data  = $urandom;
        rq.req_hex   = 1'($urandom);
        n = 0;
        while (busy && n < 100) begin
            n++;
            p = exp_pos();
            check({tag, "_hold_dig"}, 64'(dig), 64'(old[p]));
            check({tag, "_ready_busy"}, 64'(rq.req_ready), 64'd0);
            if (spam && n < 20) begin
                rq.req_valid = 1'b1;
                rq.req_data  = $urandom;
                rq.req_hex   = 1'($urandom);
            end else begin
                rq.req_valid = 1'b0;
            end
            tick();
        end
        rq.req_valid = 1'b0;
        check({tag, "_busy_len"}, 64'(n), hex ? 64'd1 : 64'd33);
        check({tag, "_ready_post"}, 64'(rq.req_ready), 64'd1);
        model_set(v, hex);
        for (int k = 0; k < 8 * SD; k++) begin
            check_scan(tag);
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(rq.req_ready), 64'd1);
        check({tag, "_busy"},  64'(busy),  64'd0);
        check({tag, "_dig"},   64'(dig),   64'd0);
        check({tag, "_pos"},   64'(pos),   64'd0);
        check({tag, "_off"},   64'(off),   64'd0);
        check({tag, "_point"}, 64'(point), 64'd0);
        check({tag, "_ovf"},   64'(ovf),   64'd0);
    endtask

    initial begin
        logic [31:0] v;
        bit          h;
        rst          = 1'b1;
        rq.req_valid = 1'b0;
        rq.req_data  = '0;
        rq.req_hex   = 1'b0;
        for (int i = 0; i < 8; i++) m_dig[i] = 0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;

        txn(32'h00C0FFEE, 1'b1, 1'b0, "hex_c0ffee");
        txn(32'd12345678, 1'b0, 1'b1, "dec_12345678");
        txn(32'd4294967295, 1'b0, 1'b0, "dec_max");

        // Abort a conversion part-way through.
        rq.req_valid = 1'b1;
        rq.req_data  = 32'd87654321;
        rq.req_hex   = 1'b0;
        tick();
        rq.req_valid = 1'b0;
        repeat (9) tick();
        check("mid_conv_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_dig[i] = 0;
        m_ovf = 1'b0;
        txn(32'd0, 1'b0, 1'b0, "dec_zero");

        for (int t = 0; t < 14; t++) begin
            h = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom_range(100000000, 32'hFFFFFFFF);
                2:       v = $urandom_range(0, 99999999);
                default: v = $urandom;
            endcase
            txn(v, h, !h && ($urandom_range(0, 1) == 1), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
